// File: rtl/timer_seq_ctrl.sv
// Drives a down-counter through R intervals of N+2 cycles (LOAD + N+1 WAIT), ticking once per expiry.
// Requests only accepted in IDLE; response held until resp_rdy. TIMER_SEQ_ABORT_EN adds an abort input.
module timer_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [CNT_W-1:0] req_len,
  input  logic [REP_W-1:0] req_reps,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_done,
  output logic             tick,
  output logic             busy,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [REP_W-1:0] resp_reps
`ifdef TIMER_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [REP_W-1:0] reps_left_q, reps_left_d;
  logic [REP_W-1:0] done_cnt_q, done_cnt_d;
  logic             abort_w;

`ifdef TIMER_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign req_rdy   = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign cnt_load  = (state_q == ST_LOAD);
  assign cnt_in    = len_q;
  assign resp_val  = (state_q == ST_RESP);
  assign resp_reps = done_cnt_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    reps_left_d = reps_left_q;
    done_cnt_d  = done_cnt_q;
    tick        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          len_d       = req_len;
          reps_left_d = (req_reps == '0) ? REP_W'(1) : req_reps;
          done_cnt_d  = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // cnt_done still reflects the previous count here, so it is not looked at
        state_d = abort_w ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (abort_w) begin
          state_d = ST_RESP;
        end else if (cnt_done) begin
          tick        = 1'b1;
          done_cnt_d  = done_cnt_q + REP_W'(1);
          reps_left_d = reps_left_q - REP_W'(1);
          state_d     = (reps_left_q == REP_W'(1)) ? ST_RESP : ST_LOAD;
        end
      end
      ST_RESP: begin
        if (resp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      reps_left_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      reps_left_q <= reps_left_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: downstream counter model plus an interval-arithmetic reference checked every cycle.
module tb_timer_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic [15:0] req_len;
  logic [7:0]  req_reps;
  logic        cnt_load;
  logic [15:0] cnt_in;
  logic        cnt_done;
  logic        tick;
  logic        busy;
  logic        resp_val;
  logic        resp_rdy;
  logic [7:0]  resp_reps;
`ifdef TIMER_SEQ_ABORT_EN
  logic        abort;
`endif

  timer_seq_ctrl #(.CNT_W(16), .REP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_len   (req_len),
    .req_reps  (req_reps),
    .cnt_load  (cnt_load),
    .cnt_in    (cnt_in),
    .cnt_done  (cnt_done),
    .tick      (tick),
    .busy      (busy),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_reps (resp_reps)
`ifdef TIMER_SEQ_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 16-bit down-counter sharing the reset
  logic [15:0] cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= 16'd0;
    else if (cnt_load) cnt <= cnt_in;
    else if (cnt != 0) cnt <= cnt - 16'd1;
  end
  assign cnt_done = (cnt == 16'd0);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: a session is (handshake cycle, N, R); outputs follow from cycle offsets
  int m_mode = 0;  // 0 idle, 1 running, 2 responding
  int m_hs, m_n, m_r, m_len, m_resp;
  int hs_cyc, resp_hs_cyc, last_resp;
  int tick_cnt, first_tick, last_tick;
  bit hs_pending;
  int rel, per, pos;
  bit e_load, e_tick, e_busy, e_rv, e_rdy, ab_now;

  initial begin
    m_len = 0; m_resp = 0; hs_cyc = 0; resp_hs_cyc = 0; last_resp = 0;
    tick_cnt = 0; first_tick = -1; last_tick = -1; hs_pending = 0;
  end

  always @(negedge clk) begin
`ifdef TIMER_SEQ_ABORT_EN
    ab_now = abort;
`else
    ab_now = 1'b0;
`endif
    e_load = 0; e_tick = 0; e_busy = 0; e_rv = 0; e_rdy = 0;
    if (!rst) begin
      m_mode = 0; m_len = 0; m_resp = 0;
    end
    per = m_n + 2;
    if (m_mode == 1) begin
      rel = cyc - m_hs;
      if (rel > m_r * per) begin
        m_mode = 2;
        m_resp = m_r;
      end
    end
    case (m_mode)
      0: e_rdy = 1;
      1: begin
        pos    = (rel - 1) % per;
        e_busy = 1;
        e_load = (pos == 0);
        e_tick = (pos == per - 1) && !ab_now;
      end
      default: begin
        e_busy = 1;
        e_rv   = 1;
      end
    endcase
    chk("req_rdy", req_rdy, e_rdy);
    chk("busy", busy, e_busy);
    chk("cnt_load", cnt_load, e_load);
    chk("cnt_in", cnt_in, m_len);
    chk("tick", tick, e_tick);
    chk("resp_val", resp_val, e_rv);
    if (!rst || e_rv) chk("resp_reps", resp_reps, m_resp);
    if (tick) begin
      tick_cnt++;
      if (first_tick < 0) first_tick = cyc;
      last_tick = cyc;
    end
    if (rst) begin
      if (m_mode == 0 && req_val) begin
        m_mode = 1; m_hs = cyc; m_n = int'(req_len);
        m_r = (req_reps == 0) ? 1 : int'(req_reps);
        m_len = int'(req_len);
        hs_cyc = cyc; hs_pending = 1;
      end else if (m_mode == 1 && ab_now) begin
        m_mode = 2;
        m_resp = (rel - 1) / per;
      end else if (m_mode == 2 && resp_rdy) begin
        m_mode = 0;
        resp_hs_cyc = cyc;
        last_resp = int'(resp_reps);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (hs_pending) begin
        hs_pending = 0;
        req_val = 0;
        return;
      end
    end
    chk("request_handshake_timeout", 0, 1);
    req_val = 0;
  endtask

  task automatic do_req(input int len, input int reps);
    req_len  = 16'(len);
    req_reps = 8'(reps);
    req_val  = 1;
    wait_hs(200);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == 0) begin
`ifdef TIMER_SEQ_ABORT_EN
        abort = 0;
`endif
        return;
      end
      step(1);
      if (rnd) begin
        resp_rdy = ($urandom_range(0, 2) != 0);
`ifdef TIMER_SEQ_ABORT_EN
        abort = ($urandom_range(0, 39) == 0);
`endif
      end
    end
    chk("completion_timeout", 0, 1);
  endtask

  task automatic clear_ticks();
    tick_cnt = 0; first_tick = -1; last_tick = -1;
  endtask

  initial begin
    rst = 0; req_val = 0; req_len = 0; req_reps = 0; resp_rdy = 0;
`ifdef TIMER_SEQ_ABORT_EN
    abort = 0;
`endif
    step(2);
    rst = 1;
    step(10);
    chk("idle_req_rdy", req_rdy, 1);
    chk("idle_busy", busy, 0);

    // Single interval
    resp_rdy = 1;
    clear_ticks();
    do_req(5, 1);
    wait_done(100, 0);
    chk("single_tick_latency", first_tick - hs_cyc, 7);
    chk("single_tick_count", tick_cnt, 1);
    chk("single_resp_reps", last_resp, 1);

    // Zero length, three repetitions
    step(1);
    clear_ticks();
    do_req(0, 3);
    wait_done(100, 0);
    chk("zero_len_ticks", tick_cnt, 3);
    chk("zero_len_span", last_tick - first_tick, 4);
    chk("zero_len_resp", last_resp, 3);

    // R=0 behaves as one repetition
    clear_ticks();
    do_req(3, 0);
    wait_done(100, 0);
    chk("reps0_ticks", tick_cnt, 1);
    chk("reps0_resp", last_resp, 1);

    // Response backpressure with a blocked request
    resp_rdy = 0;
    do_req(2, 2);
    for (int i = 0; i < 50 && m_mode != 2; i++) step(1);
    step(8);
    chk("bp_resp_val_held", resp_val, 1);
    chk("bp_resp_reps_held", resp_reps, 2);
    req_len = 16'd9; req_reps = 8'd1; req_val = 1;
    step(3);
    chk("bp_req_blocked", req_rdy, 0);
    resp_rdy = 1;
    wait_hs(20);
    chk("bp_accept_gap", hs_cyc - resp_hs_cyc, 1);
    wait_done(100, 0);

    // Reset in the middle of WAIT
    clear_ticks();
    do_req(20, 4);
    step(9);
    rst = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_load", cnt_load, 0);
    chk("midrst_cnt_in", cnt_in, 0);
    chk("midrst_resp_val", resp_val, 0);
    chk("midrst_req_rdy", req_rdy, 1);
    step(2);
    rst = 1;
    step(3);
    chk("midrst_no_tick", tick_cnt, 0);

    // Full-scale repetition count
    clear_ticks();
    do_req(0, 255);
    wait_done(2000, 0);
    chk("r255_ticks", tick_cnt, 255);
    chk("r255_resp", last_resp, 255);

`ifdef TIMER_SEQ_ABORT_EN
    // Abort during the third WAIT
    clear_ticks();
    do_req(4, 5);
    step(15);
    abort = 1;
    step(1);
    abort = 0;
    wait_done(100, 0);
    chk("abort_ticks", tick_cnt, 2);
    chk("abort_resp", last_resp, 2);
`endif

    // Randomized sessions
    for (int s = 0; s < 30; s++) begin
      step($urandom_range(0, 2));
      do_req($urandom_range(0, 10), $urandom_range(0, 5));
      wait_done(600, 1);
      resp_rdy = 1;
    end
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
- Sequencer that drives the 16-bit down-counter directly downstream of it: accepts a (length, repetitions) request over a val/rdy handshake, issues the counter's load and in values, consumes the counter's done, and emits one tick per expiry.
- Reports completion over a val/rdy response channel.
- Sits between the control logic that requests timed intervals and the counter datapath.

Parameters:
- CNT_W, 16, width of the interval length and of the counter interface (matches the 16-bit counter).
- REP_W, 8, width of the repetition count and of the completed-repetition count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_val  input  1  request valid.
- req_rdy  output  1  request ready; high only in IDLE.
- req_len  input  CNT_W  interval length N, captured on request handshake.
- req_reps  input  REP_W  repetitions R, captured on request handshake; 0 is treated as 1.
- cnt_load  output  1  to counter load.
- cnt_in  output  CNT_W  to counter in; always equals the captured length register.
- cnt_done  input  1  from counter done; combinational, high while count==0.
- tick  output  1  one-cycle pulse on each interval expiry.
- busy  output  1  high in any state other than IDLE.
- resp_val  output  1  completion valid.
- resp_rdy  input  1  completion ready.
- resp_reps  output  REP_W  repetitions completed; held stable while resp_val=1.

Behaviour:
- Reset (rst=0, async): state=IDLE; len_q=0, reps_left=0, done_cnt=0. Outputs after reset: cnt_load=0, cnt_in=0, tick=0, busy=0, resp_val=0, resp_reps=0, req_rdy=1. The counter shares reset, so both blocks restart together.
- States: IDLE, LOAD, WAIT, RESP. Encoding is free.
- IDLE:
  - req_rdy=1.
  - On req_val=1: len_q<=req_len; reps_left<=(req_reps==0 ? 1 : req_reps); done_cnt<=0; go to LOAD.
- LOAD:
  - cnt_load=1 for exactly one cycle.
  - cnt_done is ignored in this cycle, because it reflects the stale count.
  - Next state is WAIT.
- WAIT:
  - cnt_load=0. The counter holds N in the first WAIT cycle and decrements by 1 each cycle.
  - When cnt_done=1: tick=1 that cycle, done_cnt<=done_cnt+1, reps_left<=reps_left-1.
  - If reps_left==1, go to RESP; otherwise go to LOAD.
  - WAIT lasts N+1 cycles, so one repetition takes N+2 cycles (LOAD + WAIT). N=0 gives a 2-cycle period.
- tick is combinational: (state==WAIT && cnt_done). It is never high outside WAIT.
- RESP:
  - resp_val=1, resp_reps=done_cnt.
  - On resp_rdy=1, go to IDLE; resp_val drops the next cycle.
  - resp_rdy is ignored outside RESP.
- Request timing:
  - req_val while busy is not accepted (req_rdy=0). The request must be held until handshake.
  - A request can be accepted in the cycle after the RESP handshake (back-to-back: IDLE lasts at least 1 cycle).
- Width rules:
  - done_cnt and reps_left are REP_W bits. R=255 completes 255 ticks, with no wrap.
  - N=65535 waits 65536 cycles; no timeout.
- Reset mid-operation: immediate return to IDLE. No tick or resp is emitted for the partial interval, and captured values are cleared.

Optional Feature:
- Macro: TIMER_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or WAIT: go to RESP next cycle. resp_reps=done_cnt (reps completed so far); no tick in that cycle even if cnt_done=1 (abort wins). cnt_load is not asserted again. The counter is left to run down on its own.
  - abort is ignored in IDLE and RESP.
- Not defined: no abort port; the sequence always runs all R repetitions.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> req_rdy=1, busy=0, cnt_load=0, cnt_in=0, resp_val=0. Hold 10 cycles -> no change.
- Single interval: req_len=5, req_reps=1, resp_rdy=1 -> cnt_load high 1 cycle with cnt_in=5; tick exactly once, 7 cycles after the handshake cycle; resp_val=1 with resp_reps=1; back to IDLE.
- Repeats and zero-length: req_len=0, req_reps=3 -> ticks every 2 cycles, 3 ticks total; resp_reps=3. Then req_len=3, req_reps=0 -> treated as R=1, resp_reps=1.
- Response backpressure and blocked request: hold resp_rdy=0 for 8 cycles in RESP -> resp_val and resp_reps stable, req_rdy=0. Assert req_val with req_len=9 -> not accepted until 1 cycle after resp_rdy=1.
- Reset mid-WAIT: req_len=20, req_reps=4, assert rst at cycle 10 -> all outputs at reset values immediately; no tick and no resp.
- TIMER_SEQ_ABORT_EN: req_len=4, req_reps=5, abort pulsed during the 3rd WAIT -> ticks=2, next state RESP with resp_reps=2, no further cnt_load.
